// File: rtl/mips_pkg.sv
// Shared MIPS_R2000 bench definitions: instruction-memory geometry and
// the readback engine state encoding.
package mips_pkg;

  localparam int IMEM_ADDR_W    = 10;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    OUT   = 2'd2,
    DONE  = 2'd3
  } rb_state_t;

endpackage

// File: rtl/imem_word_packer.sv
// Four-lane byte assembler: bytes arrive b0 first and are shifted down so
// the finished word reads {b3,b2,b1,b0}.
module imem_word_packer
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        load,
  input  logic [7:0]  lane_byte,
  output logic [31:0] word,
  output logic        last
);

  logic [1:0] lane;

  assign last = load && (lane == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      word <= '0;
      lane <= '0;
    end else if (clear) begin
      lane <= '0;
    end else if (load) begin
      word <= {lane_byte, word[31:8]};
      lane <= lane + 2'd1;
    end
  end

endmodule

// File: rtl/imem_readback.sv
// Instruction-memory readback engine: walks a word-aligned region through the
// synchronous byte read port and streams little-endian words over valid/ready.
module imem_readback
  import mips_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [7:0]        mem_rdata,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [31:0]       word_data,
  output logic [ADDR_W-1:0] word_addr,
  output logic              busy,
  output logic              done
);

  rb_state_t         state, state_nxt;
  logic [ADDR_W-1:0] cur;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        issue;
  logic              rd_pend_p1;
  logic              pk_clear;
  logic              pk_last;
  logic [31:0]       pk_word;

  logic start_go;
  logic handshake;

  assign start_go  = (state == IDLE) && start && (word_count != '0);
  assign handshake = (state == OUT) && word_ready;

  // issue[2] marks that all four reads are out; FETCH then waits for lane 3
  assign mem_rd_en  = (state == FETCH) && !issue[2];
  assign mem_addr   = mem_rd_en ? cur + ADDR_W'(issue[1:0]) : '0;
  assign word_valid = (state == OUT);
  assign word_data  = pk_word;
  assign word_addr  = cur;
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);

  always_comb begin
    state_nxt = state;
    pk_clear  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (word_count != '0) begin
            state_nxt = FETCH;
            pk_clear  = 1'b1;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      FETCH: begin
        if (pk_last) state_nxt = OUT;
      end
      OUT: begin
        if (word_ready) begin
          if (cnt <= CNT_W'(1)) begin
            state_nxt = DONE;
          end else begin
            state_nxt = FETCH;
            pk_clear  = 1'b1;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cur        <= '0;
      cnt        <= '0;
      issue      <= '0;
      rd_pend_p1 <= 1'b0;
    end else begin
      state      <= state_nxt;
      // read data returns one cycle after the strobe
      rd_pend_p1 <= mem_rd_en;
      if (start_go) begin
        cur   <= base_addr & ~ADDR_W'(3);
        cnt   <= word_count;
        issue <= '0;
      end else if (mem_rd_en) begin
        issue <= issue + 3'd1;
      end else if (handshake) begin
        cur   <= cur + ADDR_W'(BYTES_PER_WORD);
        cnt   <= (cnt != '0) ? cnt - CNT_W'(1) : '0;
        issue <= '0;
      end
    end
  end

  imem_word_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (pk_clear),
    .load      (rd_pend_p1),
    .lane_byte (mem_rdata),
    .word      (pk_word),
    .last      (pk_last)
  );

endmodule

// File: doc/imem_readback.md
# imem_readback

Instruction-memory readback engine for the MIPS_R2000 bench and debug path. It is the reader counterpart of the byte-wise instruction-memory loader. On a start command it walks a contiguous region of the byte-addressed instruction memory through that memory's synchronous read port. It assembles each group of four bytes into a little-endian 32-bit instruction word and streams the words out over a valid/ready handshake. Benches use it to confirm that a loaded program matches what was written.

## Interface
Parameters:
- ADDR_W, 10: byte-address width of instruction memory (1 KiB)
- CNT_W, 8: width of word_count

Ports (one clock; reset is synchronous and active-low):
- clk  in  1: clock, all state updates on rising edge
- rst  in  1: synchronous active-low reset
- start  in  1: begin a readback; sampled only in IDLE
- base_addr  in  ADDR_W: first byte address; bits [1:0] are ignored and forced to 0
- word_count  in  CNT_W: number of words to read
- mem_addr  out  ADDR_W: byte address to instruction memory
- mem_rd_en  out  1: read strobe
- mem_rdata  in  8: byte returned one cycle after mem_rd_en
- word_valid  out  1: word_data and word_addr are valid
- word_ready  in  1: consumer accepts the word
- word_data  out  32: assembled instruction, {b3,b2,b1,b0}
- word_addr  out  ADDR_W: byte address of b0
- busy  out  1: high in every state except IDLE
- done  out  1: one-cycle pulse at the end of a readback

## Operation
- States are IDLE, FETCH, OUT and DONE.
- IDLE:
  - start=1 with word_count≠0: latch the aligned base and the count, clear the byte index, go to FETCH.
  - start=1 with word_count=0: go to DONE. No memory reads are issued.
- FETCH:
  - Issue mem_rd_en=1 for 4 consecutive cycles, with mem_addr = cur+0, +1, +2, +3.
  - Capture mem_rdata one cycle after each issue into byte lane k (k = 0..3).
  - After lane 3 is captured, go to OUT.
- OUT:
  - Hold word_valid=1 with word_data and word_addr stable until word_valid & word_ready.
  - On the handshake: cur += 4 and count -= 1. If the new count is 0, go to DONE; otherwise go to FETCH.
- DONE: assert done for exactly one cycle, then go to IDLE.
- Arithmetic:
  - cur wraps modulo 2^ADDR_W, so 0x3FC+4 becomes 0x000.
  - count is unsigned and is never decremented below 0.
- start while busy is ignored. It does not queue and does not restart.
- mem_rd_en is 0 in IDLE, OUT and DONE.
- The engine never writes memory.

## Timing
- Reset value of every output is 0 (mem_addr, mem_rd_en, word_valid, word_data, word_addr, busy, done). The state resets to IDLE.
- Reset mid-operation abandons the current word: no partial word_valid and no done pulse.
- Start sampled at edge E0:
  - busy=1 after E0.
  - Reads are issued in the cycles after E0, E1, E2 and E3.
  - Bytes are captured at E1..E4 (mem_rdata) and latched by E5.
  - word_valid=1 after E5.
- With word_ready held high, the handshake occurs at E6, so throughput is one word per 6 cycles. Each extra cycle of ready=0 adds one cycle.
- After the last handshake: done=1 for the next cycle, then busy=0 one cycle later.
- A word_count=0 start gives done=1 one cycle after E0 and no word_valid.
- word_data and word_addr do not change while word_valid=1 and word_ready=0.

## Structure
- A shared package mips_pkg holds:
  - the state enum (IDLE/FETCH/OUT/DONE)
  - IMEM_ADDR_W
  - the BYTES_PER_WORD=4 constant, shared with the loader and the instruction memory
- Sub-module imem_word_packer contains the 4-lane byte shift/assemble register and the lane counter, with load/clear controls. The FSM and address/count logic live in imem_readback.

## Test plan
- Load bytes 01 00 42 20 at 0x000 and 02 00 63 20 at 0x004. Start with base=0 and count=2, ready held high. Expect 0x20420001@0x000 after E5, 0x20630002@0x004 six cycles later, then a single done pulse.
- Same program with ready low for 3 cycles on word 0. Expect word_valid and the data held stable, and word 1 delayed by 3 cycles.
- Start with base=0x3FC and count=2. Expect word_addr 0x3FC, then 0x000, with mem_addr wrapping cleanly.
- Start with count=0. Expect done one cycle after start, no mem_rd_en, and no word_valid.
- Assert start again while busy during FETCH. Expect no effect on the address sequence or the word count.
- Drive rst=0 during the third FETCH cycle. Expect all outputs 0 the next cycle, no done pulse, and a clean restart on a subsequent start.
